udp_tx_arbiter: RTL and testbench

//  Frame-granular arbiter sharing one UDP/IPv4 TX header inserter among N_SRC payload sources.

---
 rtl/udp_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter.sv
// rtl/udp_tx_arbiter.sv - frame-granular round-robin arbiter feeding the UDP TX header inserter
// Optional build macro: TX_ARB_PRIO_EN gives source 0 strict priority over the round-robin.
module udp_tx_arbiter #(
  parameter int N_SRC      = 4,
  parameter int IFG_CYCLES = 12,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = (N_SRC <= 2) ? 1 : $clog2(N_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC*8-1:0] s_tdata,
  input  logic [N_SRC-1:0]   s_tvalid,
  output logic [N_SRC-1:0]   s_tready,
  input  logic [N_SRC-1:0]   s_tlast,
  output logic [7:0]         m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic [SEL_W-1:0]   grant_id,
  output logic               busy,
  output logic [CNT_W-1:0]   frame_cnt
);

  // gap counter holds IFG_CYCLES-1 down to 0
  localparam int GAP_W    = (IFG_CYCLES <= 1) ? 1 : $clog2(IFG_CYCLES);
  localparam int GAP_INIT = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [SEL_W-1:0]   r_grant;
  logic [SEL_W-1:0]   r_rr_ptr;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [CNT_W-1:0]   r_frame_cnt;

  logic [N_SRC-1:0]   w_cand;
  logic               w_hi_found;
  logic [SEL_W-1:0]   w_hi_idx;
  logic [SEL_W-1:0]   w_lo_idx;
  logic [SEL_W-1:0]   w_winner;
  logic               w_eof;

  assign grant_id  = r_grant;
  assign frame_cnt = r_frame_cnt;
  assign w_eof     = (r_state == ST_PASS) & m_tvalid & m_tready & m_tlast;

  // Round-robin pick: lowest candidate above rr_ptr, else lowest candidate at or below it
  always_comb begin
    w_cand = s_tvalid;
`ifdef TX_ARB_PRIO_EN
    w_cand[0] = 1'b0;
`endif
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        if (SEL_W'(i) > r_rr_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = SEL_W'(i);
        end else begin
          w_lo_idx   = SEL_W'(i);
        end
      end
    end
    w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
`ifdef TX_ARB_PRIO_EN
    if (s_tvalid[0]) begin
      w_winner = '0;
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: grant on any request, release on tlast, then wait out the idle gap
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (|s_tvalid) w_next = ST_PASS;
      ST_PASS: if (w_eof) w_next = (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:  if (r_gap_cnt == '0) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs: passthrough from the granted source only while in PASS
  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    busy     = (r_state != ST_IDLE);
    if (r_state == ST_PASS) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (r_grant == SEL_W'(i)) begin
          m_tdata     = s_tdata[i*8 +: 8];
          m_tvalid    = s_tvalid[i];
          m_tlast     = s_tlast[i];
          s_tready[i] = m_tready;
        end
      end
    end
  end

  // Grant latch, round-robin pointer, gap countdown and completed-frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant     <= '0;
      r_rr_ptr    <= SEL_W'(N_SRC - 1);
      r_gap_cnt   <= '0;
      r_frame_cnt <= '0;
    end else begin
      if ((r_state == ST_IDLE) && (|s_tvalid)) begin
        r_grant <= w_winner;
      end
      if (w_eof) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
        r_gap_cnt   <= GAP_W'(GAP_INIT);
`ifdef TX_ARB_PRIO_EN
        if (r_grant != '0) begin
          r_rr_ptr <= r_grant;
        end
`else
        r_rr_ptr <= r_grant;
`endif
      end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb/tb_udp_tx_arbiter.sv - self-checking bench for udp_tx_arbiter
module tb_udp_tx_arbiter;

  localparam int N   = 4;
  localparam int IFG = 2;
  localparam int SW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*8-1:0] s_tdata;
  logic [N-1:0]   s_tvalid, s_tready, s_tlast;
  logic [7:0]     m_tdata;
  logic           m_tvalid, m_tready, m_tlast;
  logic [SW-1:0]  grant_id;
  logic           busy;
  logic [31:0]    frame_cnt;

  logic [N*8-1:0] z_tdata;
  logic [N-1:0]   z_tvalid, z_tready, z_tlast;
  logic [7:0]     zm_tdata;
  logic           zm_tvalid, zm_tready, zm_tlast;
  logic [SW-1:0]  z_grant;
  logic           z_busy;
  logic [31:0]    z_cnt;

  udp_tx_arbiter #(.N_SRC(N), .IFG_CYCLES(IFG), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .grant_id(grant_id), .busy(busy), .frame_cnt(frame_cnt)
  );

  udp_tx_arbiter #(.N_SRC(N), .IFG_CYCLES(0), .CNT_W(32)) u_dut_z (
    .clk(clk), .rst(rst),
    .s_tdata(z_tdata), .s_tvalid(z_tvalid), .s_tready(z_tready), .s_tlast(z_tlast),
    .m_tdata(zm_tdata), .m_tvalid(zm_tvalid), .m_tready(zm_tready), .m_tlast(zm_tlast),
    .grant_id(z_grant), .busy(z_busy), .frame_cnt(z_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // per-source beat queues: {bubble, last, data}
  logic [9:0] srcq [N][$];
  logic       rdyq [$];
  int         rdy_pct = 100;

  // reference model
  bit          m_act;
  int          m_grant;
  int          m_last;
  int          m_gap;
  logic [31:0] m_cnt;

  // observations taken from the DUT output side
  int          grant_log [$];
  int          gap_log [$];
  logic [8:0]  out_log [$];
  logic [7:0]  exp_bytes [$];
  int          eof_seen = 0;
  int          eof_cyc = 0;
  bit          after_eof = 0;
  int          cyc = 0;
  int          loaded = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int model_winner(input logic [N-1:0] v, input int last);
    int w;
    int idx;
    w = -1;
`ifdef TX_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
`ifdef TX_ARB_PRIO_EN
      if (idx != 0 && v[idx] && w < 0) w = idx;
`else
      if (v[idx] && w < 0) w = idx;
`endif
    end
    return w;
  endfunction

  task automatic load_frame(input int s, input int len, input int bub_after, input int bub_len, input bit rnd);
    logic [7:0] x;
    int nb;
    exp_bytes.delete();
    for (int b = 0; b < len; b++) begin
      x = 8'($urandom);
      exp_bytes.push_back(x);
      srcq[s].push_back({1'b0, 1'(b == len - 1), x});
      if (b < len - 1) begin
        nb = 0;
        if (b == bub_after) nb = bub_len;
        else if (rnd && $urandom_range(0, 3) == 0) nb = $urandom_range(1, 3);
        for (int j = 0; j < nb; j++) srcq[s].push_back(10'h200);
      end
    end
    loaded++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0 && !srcq[i][0][9]) begin
        s_tvalid[i]        = 1'b1;
        s_tlast[i]         = srcq[i][0][8];
        s_tdata[i*8 +: 8]  = srcq[i][0][7:0];
      end else begin
        s_tvalid[i]        = 1'b0;
        s_tlast[i]         = 1'($urandom);
        s_tdata[i*8 +: 8]  = 8'($urandom);
      end
    end
    if (rdyq.size() > 0) m_tready = rdyq.pop_front();
    else m_tready = ($urandom_range(1, 100) <= rdy_pct);
  endtask

  task automatic tick();
    logic [N-1:0]   v, l, er;
    logic [N*8-1:0] d;
    logic           r, ev, el;
    logic [7:0]     ed;
    @(negedge clk);
    drive();
    #1;
    v = s_tvalid; l = s_tlast; d = s_tdata; r = m_tready;
    ev = 1'b0; el = 1'b0; ed = 8'h00; er = '0;
    if (m_act) begin
      ev = v[m_grant]; el = l[m_grant]; ed = d[m_grant*8 +: 8]; er[m_grant] = r;
    end
    chk("m_tvalid", m_tvalid, ev);
    chk("m_tlast", m_tlast, el);
    chk("m_tdata", m_tdata, ed);
    chk("s_tready", s_tready, er);
    chk("busy", busy, (m_act || m_gap > 0));
    chk("grant_id", grant_id, m_grant);
    chk("frame_cnt", frame_cnt, m_cnt);
    if (m_tvalid === 1'b1 && after_eof) begin
      gap_log.push_back(cyc - eof_cyc - 1);
      after_eof = 0;
    end
    if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
      out_log.push_back({m_tlast, m_tdata});
      if (m_tlast === 1'b1) begin
        grant_log.push_back(int'(grant_id));
        eof_seen++;
        eof_cyc = cyc;
        after_eof = 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        if (srcq[i][0][9]) void'(srcq[i].pop_front());
        else if (s_tready[i] === 1'b1) void'(srcq[i].pop_front());
      end
    end
    if (m_act) begin
      if (v[m_grant] && l[m_grant] && r) begin
        m_act = 0;
        m_cnt = m_cnt + 1;
        m_gap = IFG;
`ifdef TX_ARB_PRIO_EN
        if (m_grant != 0) m_last = m_grant;
`else
        m_last = m_grant;
`endif
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (|v) begin
      m_grant = model_winner(v, m_last);
      m_act = 1;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    rdyq.delete();
    m_act = 0; m_gap = 0; m_grant = 0; m_last = N - 1; m_cnt = 0; after_eof = 0;
    #1;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_z_cnt", z_cnt, 0);
  endtask

  task automatic run_eofs(input int n, input int budget);
    int target;
    int k;
    target = eof_seen + n;
    k = 0;
    while (eof_seen < target && k < budget) begin
      tick();
      k++;
    end
    chk("eof_budget", eof_seen, target);
  endtask

  function automatic int pending();
    int p;
    p = (m_act || m_gap > 0) ? 1 : 0;
    for (int i = 0; i < N; i++) p += srcq[i].size();
    return p;
  endfunction

  task automatic run_drain(input int budget);
    int k;
    k = 0;
    while (pending() > 0 && k < budget) begin
      tick();
      k++;
    end
    chk("drain_budget", pending(), 0);
  endtask

  initial begin
    int t1_ord [5];
    int t6_ord [4];
    int k;
    rst = 1'b0;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
    z_tvalid = '0; z_tlast = '0; z_tdata = '0; zm_tready = 1'b0;

    do_reset();

    // single-byte frames from sources 0 and 1 with no inter-frame gap
    @(negedge clk);
    z_tvalid = 4'b0011; z_tlast = 4'b0011; z_tdata = 32'h0000_B1A0; zm_tready = 1'b1;
    #1;
    chk("t4_idle_valid", zm_tvalid, 0);
    chk("t4_idle_ready", z_tready, 0);
    @(negedge clk); #1;
    chk("t4_f0_valid", zm_tvalid, 1);
    chk("t4_f0_data", zm_tdata, 8'hA0);
    chk("t4_f0_last", zm_tlast, 1);
    chk("t4_f0_ready", z_tready, 4'b0001);
    chk("t4_f0_grant", z_grant, 0);
    @(negedge clk);
    z_tvalid = 4'b0010;
    #1;
    chk("t4_idle2_valid", zm_tvalid, 0);
    chk("t4_idle2_busy", z_busy, 0);
    chk("t4_cnt1", z_cnt, 1);
    @(negedge clk); #1;
    chk("t4_f1_valid", zm_tvalid, 1);
    chk("t4_f1_data", zm_tdata, 8'hB1);
    chk("t4_f1_grant", z_grant, 1);
    chk("t4_f1_ready", z_tready, 4'b0010);
    @(negedge clk);
    z_tvalid = '0; z_tlast = '0;
    #1;
    chk("t4_cnt2", z_cnt, 2);
    chk("t4_end_busy", z_busy, 0);

    // all sources request 3-byte frames, source 0 queues a second one
    rdy_pct = 100;
    for (int s = 0; s < N; s++) load_frame(s, 3, -1, 0, 0);
    load_frame(0, 3, -1, 0, 0);
    grant_log.delete(); gap_log.delete();
`ifdef TX_ARB_PRIO_EN
    t1_ord = '{0, 0, 1, 2, 3};
`else
    t1_ord = '{0, 1, 2, 3, 0};
`endif
    run_eofs(4, 200);
    tick();
    chk("t1_cnt4", frame_cnt, 4);
    run_eofs(1, 100);
    chk("t1_nframes", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("t1_order", grant_log[i], t1_ord[i]);
    chk("t1_ngaps", gap_log.size(), 4);
    for (int i = 0; i < gap_log.size(); i++) chk("t1_gap", gap_log[i], IFG + 1);
    run_drain(100);

    // header stall then toggling ready on a 5-byte frame from source 2
    load_frame(2, 5, -1, 0, 0);
    for (int i = 0; i < 43; i++) rdyq.push_back(1'b0);
    rdyq.push_back(1'b1); rdyq.push_back(1'b0); rdyq.push_back(1'b1);
    out_log.delete();
    run_eofs(1, 200);
    chk("t2_nbytes", out_log.size(), 5);
    for (int i = 0; i < 5 && i < out_log.size(); i++) begin
      chk("t2_byte", out_log[i][7:0], exp_bytes[i]);
      chk("t2_last", out_log[i][8], (i == 4));
    end
    run_drain(100);

    // source 1 stalls mid-frame while source 3 waits
    load_frame(1, 4, 1, 4, 0);
    grant_log.delete();
    tick();
    tick();
    load_frame(3, 2, -1, 0, 0);
    run_eofs(2, 100);
    chk("t3_nframes", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t3_first", grant_log[0], 1);
      chk("t3_second", grant_log[1], 3);
    end
    run_drain(100);

    // reset on the third byte of a source 2 frame
    load_frame(2, 5, -1, 0, 0);
    k = 0;
    while (srcq[2].size() > 3 && k < 60) begin
      tick();
      k++;
    end
    chk("t5_reach", srcq[2].size(), 3);
    do_reset();
    load_frame(3, 2, -1, 0, 0);
    load_frame(1, 2, -1, 0, 0);
    grant_log.delete();
    run_eofs(2, 100);
    chk("t5_nframes", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t5_first", grant_log[0], 1);
      chk("t5_second", grant_log[1], 3);
    end

    // sources 0 and 3 both requesting continuously
    do_reset();
    load_frame(0, 2, -1, 0, 0); load_frame(0, 2, -1, 0, 0);
    load_frame(3, 2, -1, 0, 0); load_frame(3, 2, -1, 0, 0);
    grant_log.delete();
`ifdef TX_ARB_PRIO_EN
    t6_ord = '{0, 0, 3, 3};
`else
    t6_ord = '{0, 3, 0, 3};
`endif
    run_eofs(4, 200);
    chk("t6_nframes", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("t6_order", grant_log[i], t6_ord[i]);
    run_drain(100);

    // randomized traffic: random sources, lengths, bubbles and ready
    do_reset();
    loaded = 0;
    rdy_pct = 70;
    for (int b = 0; b < 4; b++) begin
      for (int f = 0; f < 10; f++) load_frame($urandom_range(0, N - 1), $urandom_range(1, 8), -1, 0, 1);
      k = $urandom_range(50, 150);
      for (int c = 0; c < k; c++) tick();
    end
    run_drain(6000);
    chk("t7_frames", frame_cnt, loaded);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
